// File: rtl/stack_pkg.sv
// Shared defaults and the operation encoding for the stack controller.
package stack_pkg;
   localparam int STACK_DATA_WIDTH = 8;
   localparam int STACK_DEPTH      = 8;
   localparam int STACK_PTR_WIDTH  = $clog2(STACK_DEPTH) + 1;

   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_PUSH = 2'd1,
      OP_POP  = 2'd2
   } op_e;
endpackage

// File: rtl/stack_if.sv
// Request/acknowledge bundle between a stack client and stack_controller.
// Optional sticky err line is present when STACK_ERR_EN is defined.
// Handshake: push/pop are strobes sampled on every rising edge; an accepted
// request returns a one-cycle pushed/popped pulse on the next cycle, and
// dout is valid while popped is high.
interface stack_if #(
   parameter int DATA_WIDTH = 8,
   parameter int PTR_WIDTH  = 4
);
   logic [DATA_WIDTH-1:0] din;
   logic [DATA_WIDTH-1:0] dout;
   logic                  push;
   logic                  pop;
   logic                  pushed;
   logic                  popped;
   logic                  full;
   logic                  empty;
   logic [PTR_WIDTH-1:0]  stack_pointer;
`ifdef STACK_ERR_EN
   logic                  err;

   modport master (output din, push, pop,
                   input  dout, pushed, popped, full, empty, stack_pointer, err);
   modport slave  (input  din, push, pop,
                   output dout, pushed, popped, full, empty, stack_pointer, err);
`else
   modport master (output din, push, pop,
                   input  dout, pushed, popped, full, empty, stack_pointer);
   modport slave  (input  din, push, pop,
                   output dout, pushed, popped, full, empty, stack_pointer);
`endif
endinterface

// File: rtl/stack_mem.sv
// Stack storage: DEPTH x DATA_WIDTH array, synchronous write, registered read.
// Contents are not reset; only the read register is.
module stack_mem #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int AW         = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  we,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [AW-1:0]         raddr,
   output logic [DATA_WIDTH-1:0] rdata
);
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Read register holds between pops so dout stays stable.
   always_ff @(posedge clk) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/stack_controller.sv
// LIFO stack controller: push-priority arbitration, pointer, flags, acks.
// Define STACK_ERR_EN to add the sticky err output for rejected requests.
module stack_controller
   import stack_pkg::*;
#(
   parameter int DATA_WIDTH = STACK_DATA_WIDTH,
   parameter int DEPTH      = STACK_DEPTH,
   parameter int PTR_WIDTH  = $clog2(DEPTH) + 1
) (
   input logic    clk,
   input logic    rst,
   stack_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);
   localparam logic [PTR_WIDTH-1:0] PTR_FULL = PTR_WIDTH'(DEPTH);

   logic [PTR_WIDTH-1:0] sp;
   logic [PTR_WIDTH-1:0] sp_next;
   logic                 pushed_q;
   logic                 popped_q;
   logic                 full;
   logic                 empty;
   op_e                  op;

   assign full  = (sp == PTR_FULL);
   assign empty = (sp == '0);

   // Push wins a tie; when full the push is rejected and the pop may proceed.
   always_comb begin
      op      = OP_NONE;
      sp_next = sp;
      if (bus.push && !full) begin
         op      = OP_PUSH;
         sp_next = sp + PTR_ONE;
      end else if (bus.pop && !empty && (!bus.push || full)) begin
         op      = OP_POP;
         sp_next = sp - PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sp       <= '0;
         pushed_q <= 1'b0;
         popped_q <= 1'b0;
      end else begin
         sp       <= sp_next;
         pushed_q <= (op == OP_PUSH);
         popped_q <= (op == OP_POP);
      end
   end

   stack_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk   (clk),
      .rst   (rst),
      .we    (op == OP_PUSH),
      .waddr (AW'(sp)),
      .wdata (bus.din),
      .re    (op == OP_POP),
      .raddr (AW'(sp - PTR_ONE)),
      .rdata (bus.dout)
   );

   assign bus.pushed        = pushed_q;
   assign bus.popped        = popped_q;
   assign bus.full          = full;
   assign bus.empty         = empty;
   assign bus.stack_pointer = sp;

`ifdef STACK_ERR_EN
   logic err_q;
   logic err_set;

   // A pop masked by a concurrent accepted push is not an error.
   assign err_set = (bus.push && full) || (bus.pop && !bus.push && empty);

   always_ff @(posedge clk) begin
      if (rst)          err_q <= 1'b0;
      else if (err_set) err_q <= 1'b1;
   end

   assign bus.err = err_q;
`endif
endmodule

// File: tb/tb_stack_controller.sv
// Directed self-checking bench for stack_controller (default DATA_WIDTH=8, DEPTH=8).
module tb_stack_controller;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_fail;

   stack_if #(.DATA_WIDTH(8), .PTR_WIDTH(4)) bus ();

   stack_controller #(.DATA_WIDTH(8), .DEPTH(8), .PTR_WIDTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      bus.push = 1'b0;
      bus.pop  = 1'b0;
      bus.din  = '0;
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   // one-cycle request strobe; outputs observed reflect that edge
   task automatic drive(input logic p, input logic q, input logic [7:0] d);
      bus.push = p;
      bus.pop  = q;
      bus.din  = d;
      step();
      bus.push = 1'b0;
      bus.pop  = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      step();
      n_cmp++;
      if ({bus.empty, bus.full, bus.stack_pointer} !== {1'b1, 1'b0, 4'd0}) begin
         $display("FAIL reset_flags: got empty/full/sp=%b/%b/%0d want 1/0/0",
                  bus.empty, bus.full, bus.stack_pointer);
         n_fail++;
      end
      n_cmp++;
      if ({bus.dout, bus.pushed, bus.popped} !== {8'h00, 1'b0, 1'b0}) begin
         $display("FAIL reset_out: got dout=%h pushed=%b popped=%b want 00/0/0",
                  bus.dout, bus.pushed, bus.popped);
         n_fail++;
      end
`ifdef STACK_ERR_EN
      n_cmp++;
      if (bus.err !== 1'b0) begin
         $display("FAIL reset_err: got %b want 0", bus.err);
         n_fail++;
      end
`endif
   endtask

   task automatic test_push_pop();
      do_reset();
      drive(1'b1, 1'b0, 8'h03);
      n_cmp++;
      if ({bus.pushed, bus.popped, bus.stack_pointer} !== {1'b1, 1'b0, 4'd1}) begin
         $display("FAIL push1: got pushed=%b popped=%b sp=%0d want 1/0/1",
                  bus.pushed, bus.popped, bus.stack_pointer);
         n_fail++;
      end
      drive(1'b1, 1'b0, 8'h05);
      n_cmp++;
      if ({bus.pushed, bus.stack_pointer, bus.dout} !== {1'b1, 4'd2, 8'h00}) begin
         $display("FAIL push2: got pushed=%b sp=%0d dout=%h want 1/2/00",
                  bus.pushed, bus.stack_pointer, bus.dout);
         n_fail++;
      end
      step();
      n_cmp++;
      if (bus.pushed !== 1'b0) begin
         $display("FAIL push_pulse_end: got pushed=%b want 0", bus.pushed);
         n_fail++;
      end
      drive(1'b0, 1'b1, 8'h00);
      n_cmp++;
      if ({bus.popped, bus.dout, bus.stack_pointer} !== {1'b1, 8'h05, 4'd1}) begin
         $display("FAIL pop1: got popped=%b dout=%h sp=%0d want 1/05/1",
                  bus.popped, bus.dout, bus.stack_pointer);
         n_fail++;
      end
      step();
      n_cmp++;
      if ({bus.popped, bus.dout} !== {1'b0, 8'h05}) begin
         $display("FAIL pop_hold: got popped=%b dout=%h want 0/05", bus.popped, bus.dout);
         n_fail++;
      end
      drive(1'b0, 1'b1, 8'h00);
      n_cmp++;
      if ({bus.popped, bus.dout, bus.empty, bus.stack_pointer} !== {1'b1, 8'h03, 1'b1, 4'd0}) begin
         $display("FAIL pop2: got popped=%b dout=%h empty=%b sp=%0d want 1/03/1/0",
                  bus.popped, bus.dout, bus.empty, bus.stack_pointer);
         n_fail++;
      end
   endtask

   task automatic test_full();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b0, 8'h10 + 8'(i));
         n_cmp++;
         if ({bus.pushed, bus.stack_pointer, bus.full} !== {1'b1, 4'(i + 1), (i == 7)}) begin
            $display("FAIL fill_%0d: got pushed=%b sp=%0d full=%b want 1/%0d/%b",
                     i, bus.pushed, bus.stack_pointer, bus.full, i + 1, (i == 7));
            n_fail++;
         end
      end
      drive(1'b1, 1'b0, 8'hFF);
      n_cmp++;
      if ({bus.pushed, bus.stack_pointer, bus.full} !== {1'b0, 4'd8, 1'b1}) begin
         $display("FAIL push_full: got pushed=%b sp=%0d full=%b want 0/8/1",
                  bus.pushed, bus.stack_pointer, bus.full);
         n_fail++;
      end
      drive(1'b0, 1'b1, 8'h00);
      n_cmp++;
      if ({bus.popped, bus.dout, bus.stack_pointer, bus.full} !== {1'b1, 8'h17, 4'd7, 1'b0}) begin
         $display("FAIL pop_top: got popped=%b dout=%h sp=%0d full=%b want 1/17/7/0",
                  bus.popped, bus.dout, bus.stack_pointer, bus.full);
         n_fail++;
      end
      drive(1'b1, 1'b0, 8'h18);
      // full: push rejected, pop accepted in the same cycle
      drive(1'b1, 1'b1, 8'h99);
      n_cmp++;
      if ({bus.pushed, bus.popped, bus.dout, bus.stack_pointer} !== {1'b0, 1'b1, 8'h18, 4'd7}) begin
         $display("FAIL full_push_pop: got pushed=%b popped=%b dout=%h sp=%0d want 0/1/18/7",
                  bus.pushed, bus.popped, bus.dout, bus.stack_pointer);
         n_fail++;
      end
      drive(1'b0, 1'b1, 8'h00);
      n_cmp++;
      if ({bus.popped, bus.dout} !== {1'b1, 8'h16}) begin
         $display("FAIL pop_after_reject: got popped=%b dout=%h want 1/16", bus.popped, bus.dout);
         n_fail++;
      end
   endtask

   task automatic test_pop_empty();
      do_reset();
      drive(1'b1, 1'b0, 8'h42);
      drive(1'b0, 1'b1, 8'h00);
`ifdef STACK_ERR_EN
      n_cmp++;
      if (bus.err !== 1'b0) begin
         $display("FAIL err_clean: got %b want 0", bus.err);
         n_fail++;
      end
`endif
      drive(1'b0, 1'b1, 8'h00);
      n_cmp++;
      if ({bus.popped, bus.dout, bus.stack_pointer, bus.empty} !== {1'b0, 8'h42, 4'd0, 1'b1}) begin
         $display("FAIL pop_empty: got popped=%b dout=%h sp=%0d empty=%b want 0/42/0/1",
                  bus.popped, bus.dout, bus.stack_pointer, bus.empty);
         n_fail++;
      end
`ifdef STACK_ERR_EN
      step();
      step();
      n_cmp++;
      if (bus.err !== 1'b1) begin
         $display("FAIL err_sticky: got %b want 1", bus.err);
         n_fail++;
      end
      do_reset();
      n_cmp++;
      if (bus.err !== 1'b0) begin
         $display("FAIL err_cleared: got %b want 0", bus.err);
         n_fail++;
      end
`endif
   endtask

   task automatic test_simultaneous();
      do_reset();
      drive(1'b1, 1'b0, 8'hA1);
      drive(1'b1, 1'b0, 8'hA2);
      drive(1'b1, 1'b0, 8'hA3);
      drive(1'b0, 1'b1, 8'h00);
      drive(1'b1, 1'b1, 8'hB0);
      n_cmp++;
      if ({bus.pushed, bus.popped, bus.stack_pointer, bus.dout} !== {1'b1, 1'b0, 4'd3, 8'hA3}) begin
         $display("FAIL push_pop_tie: got pushed=%b popped=%b sp=%0d dout=%h want 1/0/3/a3",
                  bus.pushed, bus.popped, bus.stack_pointer, bus.dout);
         n_fail++;
      end
      drive(1'b0, 1'b1, 8'h00);
      n_cmp++;
      if ({bus.popped, bus.dout} !== {1'b1, 8'hB0}) begin
         $display("FAIL tie_data: got popped=%b dout=%h want 1/b0", bus.popped, bus.dout);
         n_fail++;
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      bus.push = 1'b1;
      bus.din  = 8'h08;
      for (int i = 1; i <= 3; i++) begin
         step();
         n_cmp++;
         if ({bus.pushed, bus.stack_pointer} !== {1'b1, 4'(i)}) begin
            $display("FAIL hold_push_%0d: got pushed=%b sp=%0d want 1/%0d",
                     i, bus.pushed, bus.stack_pointer, i);
            n_fail++;
         end
      end
      rst = 1'b1;
      step();
      n_cmp++;
      if ({bus.stack_pointer, bus.empty, bus.pushed, bus.popped} !== {4'd0, 1'b1, 1'b0, 1'b0}) begin
         $display("FAIL mid_reset: got sp=%0d empty=%b pushed=%b popped=%b want 0/1/0/0",
                  bus.stack_pointer, bus.empty, bus.pushed, bus.popped);
         n_fail++;
      end
      rst      = 1'b0;
      bus.push = 1'b0;
      step();
      n_cmp++;
      if ({bus.stack_pointer, bus.pushed, bus.dout} !== {4'd0, 1'b0, 8'h00}) begin
         $display("FAIL post_reset: got sp=%0d pushed=%b dout=%h want 0/0/00",
                  bus.stack_pointer, bus.pushed, bus.dout);
         n_fail++;
      end
   endtask

   initial begin
      n_cmp    = 0;
      n_fail   = 0;
      rst      = 1'b1;
      bus.push = 1'b0;
      bus.pop  = 1'b0;
      bus.din  = '0;
      test_reset();
      test_push_pop();
      test_full();
      test_pop_empty();
      test_simultaneous();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
